// File: rtl/platform_field_pkg.sv
// Shared types, default geometry and helpers for the platform field store/scroller.
package platform_field_pkg;

   typedef enum logic [2:0] {IDLE, INIT, WAIT, SCROLL, SCORE} state_e;

   localparam int          SCREEN_W_D  = 640;
   localparam int          SCREEN_H_D  = 480;
   localparam int          SCROLL_LN_D = 200;
   localparam int          MAX_SHIFT_D = 15;
   localparam int          W_EASY_D    = 64;
   localparam int          W_MED_D     = 48;
   localparam int          W_HARD_D    = 32;
   localparam logic [15:0] LFSR_SEED_D = 16'hACE1;

   function automatic logic [8:0] width_of(input logic [1:0] diff, input logic [8:0] we,
                                           input logic [8:0] wm, input logic [8:0] wh);
      case (diff)
         2'd0:    return we;
         2'd1:    return wm;
         default: return wh;
      endcase
   endfunction

   // 3-digit BCD accumulate of a 0..15 increment, pinned at 999 instead of wrapping.
   function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [3:0] b);
      logic [3:0] bt, bo;
      logic [4:0] d0, d1, d2;
      logic       c0, c1;
      bt = (b >= 4'd10) ? 4'd1 : 4'd0;
      bo = (b >= 4'd10) ? b - 4'd10 : b;
      d0 = {1'b0, a[3:0]} + {1'b0, bo};
      c0 = (d0 > 5'd9);
      if (c0) d0 = d0 - 5'd10;
      d1 = {1'b0, a[7:4]} + {1'b0, bt} + {4'b0, c0};
      c1 = (d1 > 5'd9);
      if (c1) d1 = d1 - 5'd10;
      d2 = {1'b0, a[11:8]} + {4'b0, c1};
      if (d2 > 5'd9) return 12'h999;
      return {d2[3:0], d1[3:0], d0[3:0]};
   endfunction

endpackage

// File: rtl/platform_field_lfsr16.sv
// Free-running 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   output logic [15:0] q
);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) q <= SEED;
      else          q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
   end

endmodule

// File: rtl/platform_field.sv
// N-entry platform store: initialises, scrolls and respawns platforms each frame,
// keeps a BCD score and exposes a registered random-access read port.
module platform_field
   import platform_field_pkg::*;
#(
   parameter int          NUM_PLAT  = 16,
   parameter int          SCREEN_W  = SCREEN_W_D,
   parameter int          SCREEN_H  = SCREEN_H_D,
   parameter int          SCROLL_LN = SCROLL_LN_D,
   parameter int          MAX_SHIFT = MAX_SHIFT_D,
   parameter int          W_EASY    = W_EASY_D,
   parameter int          W_MED     = W_MED_D,
   parameter int          W_HARD    = W_HARD_D,
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_D,
   localparam int         IW        = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          frame_tick,
   input  logic          start,
   input  logic [9:0]    doodle_y,
   input  logic          rising,
   input  logic [1:0]    difficulty,
   input  logic [IW-1:0] rd_idx,
   output logic [9:0]    rd_x,
   output logic [9:0]    rd_y,
   output logic [8:0]    rd_w,
   output logic [3:0]    shift_amt,
   output logic [11:0]   score_bcd,
   output logic          busy,
   output logic          overrun
);

   localparam int SPACING = SCREEN_H / NUM_PLAT;

   state_e        state_q;
   logic [IW-1:0] k_q;
   logic [3:0]    shift_q, shift_amt_q;
   logic [11:0]   score_q;
   logic          busy_q, overrun_q;
   logic [9:0]    x_q [NUM_PLAT];
   logic [9:0]    y_q [NUM_PLAT];
   logic [8:0]    w_q [NUM_PLAT];
   logic [9:0]    rd_x_q, rd_y_q;
   logic [8:0]    rd_w_q;
   logic [15:0]   lfsr_q;

   logic [8:0]    w_d;
   logic [9:0]    lim, r, x_d, y_init, gap;
   logic [10:0]   ny;
   logic [3:0]    shift_d;
   logic          last;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .Reset_n(Reset_n), .q(lfsr_q));

   always_comb begin
      w_d    = width_of(difficulty, 9'(W_EASY), 9'(W_MED), 9'(W_HARD));
      lim    = 10'(SCREEN_W) - {1'b0, w_d};
      r      = lfsr_q[9:0];
      // r < 1024 and lim > 512 for sane widths, so one subtract lands inside [0, lim).
      x_d    = (r < lim) ? r : r - lim;
      y_init = 10'(32'(k_q) * SPACING);
      ny     = {1'b0, y_q[k_q]} + {7'b0, shift_q};
      gap    = 10'(SCROLL_LN) - doodle_y;
      last   = (k_q == IW'(NUM_PLAT - 1));
      shift_d = '0;
      if (rising && doodle_y < 10'(SCROLL_LN))
         shift_d = (gap > 10'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : gap[3:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         shift_q     <= '0;
         shift_amt_q <= '0;
         score_q     <= '0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < NUM_PLAT; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            w_q[i] <= '0;
         end
      end else if (start) begin
         state_q   <= INIT;
         k_q       <= '0;
         busy_q    <= 1'b1;
         overrun_q <= 1'b0;
         score_q   <= '0;
      end else begin
         if (frame_tick && busy_q) overrun_q <= 1'b1;
         case (state_q)
            IDLE: ;
            INIT: begin
               x_q[k_q] <= x_d;
               y_q[k_q] <= y_init;
               w_q[k_q] <= w_d;
               k_q      <= k_q + 1'b1;
               if (last) begin
                  state_q <= WAIT;
                  busy_q  <= 1'b0;
               end
            end
            WAIT: begin
               if (frame_tick && shift_d != 4'd0) begin
                  shift_q <= shift_d;
                  k_q     <= '0;
                  state_q <= SCROLL;
                  busy_q  <= 1'b1;
               end
            end
            SCROLL: begin
               if (ny >= 11'(SCREEN_H)) begin
                  y_q[k_q] <= 10'(ny - 11'(SCREEN_H));
                  x_q[k_q] <= x_d;
                  w_q[k_q] <= w_d;
               end else begin
                  y_q[k_q] <= ny[9:0];
               end
               k_q <= k_q + 1'b1;
               if (last) begin
                  state_q <= SCORE;
                  busy_q  <= 1'b0;
               end
            end
            SCORE: begin
               score_q     <= bcd_add_sat(score_q, shift_q);
               shift_amt_q <= shift_q;
               state_q     <= WAIT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_x_q <= '0;
         rd_y_q <= '0;
         rd_w_q <= '0;
      end else if (32'(rd_idx) < NUM_PLAT) begin
         rd_x_q <= x_q[rd_idx];
         rd_y_q <= y_q[rd_idx];
         rd_w_q <= w_q[rd_idx];
      end else begin
         rd_x_q <= '0;
         rd_y_q <= '0;
         rd_w_q <= '0;
      end
   end

   assign rd_x      = rd_x_q;
   assign rd_y      = rd_y_q;
   assign rd_w      = rd_w_q;
   assign shift_amt = shift_amt_q;
   assign score_bcd = score_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field with an entry model and a read-port scoreboard.
module tb_platform_field;

   localparam int N = 16;

   typedef struct {
      int x;
      int y;
      int w;
   } ent_t;

   logic        Clk = 1'b0, Reset_n = 1'b0, frame_tick = 1'b0, start = 1'b0, rising = 1'b0;
   logic [9:0]  doodle_y = '0;
   logic [1:0]  difficulty = '0;
   logic [3:0]  rd_idx = '0;
   logic [9:0]  rd_x, rd_y;
   logic [8:0]  rd_w;
   logic [3:0]  shift_amt;
   logic [11:0] score_bcd;
   logic        busy, overrun;

   platform_field #(.NUM_PLAT(N)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
      .doodle_y(doodle_y), .rising(rising), .difficulty(difficulty), .rd_idx(rd_idx),
      .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w), .shift_amt(shift_amt),
      .score_bcd(score_bcd), .busy(busy), .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   // Reference LFSR, stepped in lockstep with the design's free-running one.
   logic [15:0] m_lfsr;
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) m_lfsr <= 16'hACE1;
      else          m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   int   mx [N];
   int   my [N];
   int   mw [N];
   int   m_score = 0;
   int   checks = 0, errors = 0;
   ent_t sb[$];

   function automatic int wsel(input logic [1:0] d);
      return (d == 2'd0) ? 64 : (d == 2'd1) ? 48 : 32;
   endfunction

   function automatic int randx(input logic [15:0] l, input int w);
      int rr, lim;
      rr  = int'(l[9:0]);
      lim = 640 - w;
      return (rr < lim) ? rr : rr - lim;
   endfunction

   function automatic logic [11:0] tobcd(input int v);
      return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_rd_x"}, 32'(rd_x), 0);
      chk({tag, "_rd_y"}, 32'(rd_y), 0);
      chk({tag, "_rd_w"}, 32'(rd_w), 0);
      chk({tag, "_shift"}, 32'(shift_amt), 0);
      chk({tag, "_score"}, 32'(score_bcd), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_overrun"}, 32'(overrun), 0);
   endtask

   task automatic readback(input string tag);
      ent_t e;
      for (int k = 0; k < N; k++) begin
         rd_idx = 4'(k);
         sb.push_back('{x: mx[k], y: my[k], w: mw[k]});
         @(negedge Clk);
         e = sb.pop_front();
         chk($sformatf("%s_x%0d", tag, k), 32'(rd_x), e.x);
         chk($sformatf("%s_y%0d", tag, k), 32'(rd_y), e.y);
         chk($sformatf("%s_w%0d", tag, k), 32'(rd_w), e.w);
         chk($sformatf("%s_fit%0d", tag, k), 32'(32'(rd_x) + 32'(rd_w) <= 640), 1);
      end
   endtask

   task automatic do_start(input int abort_at, input logic [1:0] d);
      difficulty = d;
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      m_score = 0;
      chk("init_busy", 32'(busy), 1);
      chk("init_score_clr", 32'(score_bcd), 0);
      chk("init_overrun_clr", 32'(overrun), 0);
      for (int k = 0; k < N; k++) begin
         if (k == abort_at) return;
         mw[k] = wsel(d);
         mx[k] = randx(m_lfsr, mw[k]);
         my[k] = k * 30;
         @(negedge Clk);
      end
      chk("init_busy_fall", 32'(busy), 0);
   endtask

   task automatic frame(input int dy, input logic r, input int inject_k, input int reset_k);
      int s, old, ny;
      s   = (r && dy < 200) ? (((200 - dy) > 15) ? 15 : 200 - dy) : 0;
      old = m_score;
      doodle_y = 10'(dy);
      rising = r;
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      if (s == 0) begin
         chk("noscroll_busy", 32'(busy), 0);
         repeat (3) @(negedge Clk);
         chk("noscroll_busy_late", 32'(busy), 0);
         chk("noscroll_score", 32'(score_bcd), 32'(tobcd(old)));
         return;
      end
      chk("scroll_busy", 32'(busy), 1);
      for (int k = 0; k < N; k++) begin
         if (k == reset_k) begin
            Reset_n = 1'b0;
            #1;
            chk_zero_outputs("midreset");
            for (int i = 0; i < N; i++) begin
               mx[i] = 0; my[i] = 0; mw[i] = 0;
            end
            m_score = 0;
            @(negedge Clk);
            Reset_n = 1'b1;
            return;
         end
         frame_tick = (k == inject_k);
         ny = my[k] + s;
         if (ny >= 480) begin
            my[k] = ny - 480;
            mw[k] = wsel(difficulty);
            mx[k] = randx(m_lfsr, mw[k]);
         end else begin
            my[k] = ny;
         end
         @(negedge Clk);
      end
      frame_tick = 1'b0;
      chk("score_latency_hold", 32'(score_bcd), 32'(tobcd(old)));
      @(negedge Clk);
      m_score = (old + s > 999) ? 999 : old + s;
      chk("frame_score", 32'(score_bcd), 32'(tobcd(m_score)));
      chk("frame_shift", 32'(shift_amt), s);
      chk("frame_busy_fall", 32'(busy), 0);
      if (inject_k >= 0) chk("overrun_set", 32'(overrun), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge Clk);
      chk_zero_outputs("reset");
      Reset_n = 1'b1;
      @(negedge Clk);

      // Idle ignores frame ticks entirely.
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      @(negedge Clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_overrun", 32'(overrun), 0);

      do_start(-1, 2'd0);
      readback("init");
      rd_idx = 4'd5;
      @(negedge Clk);
      chk("e5_y", 32'(rd_y), 150);
      chk("e5_w", 32'(rd_w), 64);

      frame(190, 1'b1, -1, -1);
      chk("score_010", 32'(score_bcd), 32'h010);
      readback("f1");
      frame(150, 1'b1, -1, -1);
      readback("f2");

      difficulty = 2'd2;
      frame(190, 1'b1, -1, -1);
      readback("wrap");
      rd_idx = 4'd15;
      @(negedge Clk);
      chk("wrap_y", 32'(rd_y), 5);
      chk("wrap_w", 32'(rd_w), 32);

      frame(190, 1'b0, -1, -1);
      frame(200, 1'b1, -1, -1);
      frame(199, 1'b1, -1, -1);
      chk("shift_one", 32'(shift_amt), 1);

      difficulty = 2'd1;
      while (m_score < 995)
         frame(200 - (((995 - m_score) > 15) ? 15 : (995 - m_score)), 1'b1, -1, -1);
      chk("score_995", 32'(score_bcd), 32'h995);
      frame(185, 1'b1, -1, -1);
      chk("score_sat", 32'(score_bcd), 32'h999);
      frame(185, 1'b1, -1, -1);
      chk("score_sat_hold", 32'(score_bcd), 32'h999);
      readback("sat");

      frame(190, 1'b1, 3, -1);
      do_start(5, 2'd0);
      do_start(-1, 2'd1);
      readback("restart");

      frame(190, 1'b1, -1, 6);
      readback("after_reset");
      do_start(-1, 2'd2);
      readback("reinit");
      frame(190, 1'b1, -1, -1);
      readback("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
